// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage load/store unit driving a word-addressed valid/ready data-memory port.
// Ports: clk/rst (async active-high); MemRead, MemWrite, Funct3, Address, WriteData from the pipeline;
// Stall, Fault (combinational), ReadData (registered load result) back to the pipeline;
// mem_req/mem_we/mem_addr/mem_be/mem_wdata (registered) and mem_ready/mem_rdata to/from memory.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [2:0]  Funct3,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   output logic        Stall,
   output logic        Fault,
   output logic [31:0] ReadData,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      state_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        req, illegal, misalign;
   logic [3:0]  be_d;
   logic [31:0] wdata_d, rdata_d;
   logic [7:0]  byte_v;
   logic [15:0] half_v;
   assign req = MemRead | MemWrite;
   // 011/110/111 are undefined; 100/101 only exist as loads
   assign illegal = (MemRead & MemWrite) | (&Funct3[1:0]) | (Funct3[2] & Funct3[1]) | (MemWrite & Funct3[2]);
   assign misalign = (Funct3[1:0] == 2'b10) ? |Address[1:0] : (Funct3[1:0] == 2'b01) & Address[0];
   // gated by rst so both read as 0 while reset is held
   assign Fault = ~rst & (state_q == IDLE) & req & (illegal | misalign);
   assign Stall = ~rst & (((state_q == IDLE) & req & ~Fault) | (state_q == BUSY));
   assign be_d = ~MemWrite ? 4'b1111 :
                 (Funct3[1:0] == 2'b00) ? 4'b0001 << Address[1:0] :
                 (Funct3[1:0] == 2'b01) ? 4'b0011 << Address[1:0] : 4'b1111;
   assign wdata_d = (Funct3[1:0] == 2'b00) ? {4{WriteData[7:0]}} :
                    (Funct3[1:0] == 2'b01) ? {2{WriteData[15:0]}} : WriteData;
   assign byte_v = mem_rdata[{off_q, 3'b000} +: 8];
   assign half_v = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
   assign rdata_d = (f3_q[1:0] == 2'b00) ? {{24{~f3_q[2] & byte_v[7]}}, byte_v} :
                    (f3_q[1:0] == 2'b01) ? {{16{~f3_q[2] & half_v[15]}}, half_v} : mem_rdata;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         f3_q      <= 3'd0;
         off_q     <= 2'd0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'd0;
         mem_be    <= 4'd0;
         mem_wdata <= 32'd0;
         ReadData  <= 32'd0;
      end else begin
         case (state_q)
            IDLE: if (req & ~Fault) begin
               state_q   <= BUSY;
               mem_req   <= 1'b1;
               mem_we    <= MemWrite;
               mem_addr  <= {Address[31:2], 2'b00};
               mem_be    <= be_d;
               mem_wdata <= wdata_d;
               f3_q      <= Funct3;
               off_q     <= Address[1:0];
            end
            BUSY: if (mem_ready) begin
               state_q <= DONE;
               mem_req <= 1'b0;
               if (!mem_we) ReadData <= rdata_d;
            end
            // DONE: the completing instruction's req is still visible here and must not re-issue
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a behavioural model.
module tb_load_store_unit;
   logic        clk = 0, rst = 1;
   logic        MemRead = 0, MemWrite = 0;
   logic [2:0]  Funct3 = 0;
   logic [31:0] Address = 0, WriteData = 0;
   logic        Stall, Fault;
   logic [31:0] ReadData;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready = 0;
   logic [31:0] mem_rdata = 0;
   int checks = 0, errors = 0;
   int hs_cnt = 0, hs_exp = 0;
   logic [31:0] last_rd = 0;

   load_store_unit dut (
      .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3),
      .Address(Address), .WriteData(WriteData), .Stall(Stall), .Fault(Fault), .ReadData(ReadData),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) if (!rst && mem_req && mem_ready) hs_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   function automatic int sz(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic m_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
      if (rd && wr) return 1;
      if (f3 == 3 || f3 == 6 || f3 == 7) return 1;
      if (wr && f3 >= 4) return 1;
      return (a % sz(f3)) != 0;
   endfunction

   function automatic logic [3:0] m_be(input logic wr, input logic [2:0] f3, input logic [31:0] a);
      logic [7:0] b;
      b = 8'(((1 << sz(f3)) - 1) << (a % 4));
      return wr ? b[3:0] : 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz(f3)) +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rw);
      longint unsigned raw, mask, v;
      int off, bits;
      off  = (a % 4) - ((a % 4) % sz(f3));
      bits = 8 * sz(f3);
      raw  = longint'(rw) >> (8 * off);
      mask = (64'd1 << bits) - 1;
      v    = raw & mask;
      if (!f3[2] && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
      return v[31:0];
   endfunction

   // starts and ends at posedge+1 of an IDLE cycle; leaves req asserted through DONE
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int waits);
      logic f;
      chk("idle_noreq", mem_req, 0);
      MemRead = rd; MemWrite = wr; Funct3 = f3; Address = a; WriteData = wd;
      f = m_fault(rd, wr, f3, a);
      @(negedge clk);
      chk("fault", Fault, f);
      chk("stall_c0", Stall, !f);
      chk("req_c0", mem_req, 0);
      if (f) begin
         @(posedge clk); #1;
         chk("fault_noreq", mem_req, 0);
         chk("fault_rd_hold", ReadData, last_rd);
      end else begin
         @(posedge clk); #1;
         for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            chk("busy_req", mem_req, 1);
            chk("busy_stall", Stall, 1);
            chk("busy_fault", Fault, 0);
            chk("mem_addr", mem_addr, a & ~32'd3);
            chk("mem_we", mem_we, wr);
            chk("mem_be", mem_be, m_be(wr, f3, a));
            if (wr) chk("mem_wdata", mem_wdata, m_wdata(f3, wd));
            mem_ready = (i == waits);
            mem_rdata = (i == waits) ? rw : $urandom;
            @(posedge clk); #1;
         end
         hs_exp++;
         if (rd) last_rd = m_rdata(f3, a, rw);
         mem_ready = 1'($urandom);
         mem_rdata = $urandom;
         @(negedge clk);
         chk("done_stall", Stall, 0);
         chk("done_req", mem_req, 0);
         chk("done_rdata", ReadData, last_rd);
         @(posedge clk); #1;
      end
      chk("handshakes", hs_cnt, hs_exp);
      MemRead = 0; MemWrite = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_stall", Stall, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_be", mem_be, 0);
      chk("rst_rdata", ReadData, 0);
      rst = 0;
      access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0);
      access(1, 0, 3'b000, 32'h103, 0, 32'h80FF1234, 3);
      chk("lb_const", ReadData, 32'hFFFFFF80);
      access(0, 1, 3'b000, 32'h202, 32'h000000AB, 0, 1);
      access(0, 1, 3'b001, 32'h202, 32'h12345678, 0, 0);
      access(1, 0, 3'b101, 32'h202, 0, 32'h80010000, 2);
      chk("lhu_const", ReadData, 32'h00008001);
      access(1, 0, 3'b010, 32'h101, 0, 0, 0);
      access(0, 1, 3'b001, 32'h003, 32'h5555, 0, 0);
      access(1, 0, 3'b011, 32'h000, 0, 0, 0);
      access(1, 1, 3'b010, 32'h000, 0, 0, 0);
      chk("fault_rd_const", ReadData, 32'h00008001);
      // reset while BUSY with mem_ready low, req still driven
      MemRead = 1; Funct3 = 3'b010; Address = 32'h40;
      @(posedge clk); #1;
      mem_ready = 0;
      chk("pre_rst_req", mem_req, 1);
      #2 rst = 1;
      #1;
      chk("arst_req", mem_req, 0);
      chk("arst_stall", Stall, 0);
      chk("arst_fault", Fault, 0);
      chk("arst_we", mem_we, 0);
      chk("arst_addr", mem_addr, 0);
      chk("arst_be", mem_be, 0);
      chk("arst_wdata", mem_wdata, 0);
      chk("arst_rdata", ReadData, 0);
      last_rd = 0;
      @(posedge clk); #1;
      rst = 0; MemRead = 0;
      access(1, 0, 3'b010, 32'h40, 0, 32'hCAFEF00D, 1);
      chk("lw_after_rst", ReadData, 32'hCAFEF00D);
      // back-to-back lw then sw, req held through DONE
      access(1, 0, 3'b010, 32'h80, 0, 32'h01020304, 0);
      access(0, 1, 3'b010, 32'h84, 32'hA5A5A5A5, 0, 0);
      chk("b2b_count", hs_cnt, hs_exp);
      for (int n = 0; n < 200; n++) begin
         logic rd, wr;
         logic [2:0] f3;
         logic [31:0] a;
         rd = 1'($urandom);
         wr = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
         f3 = 3'($urandom_range(0, 7));
         a = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit in the MEM stage, directly downstream of the ALU. It takes the ALU result as the effective address and drives a word-addressed data-memory port with a valid/ready handshake. It generates byte enables and replicated store data, and sign- or zero-extends load data. It stalls the pipeline until the memory access completes.

## Interface
- No parameters. Data and address widths are fixed at 32.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- MemRead  in  1  current MEM-stage instruction is a load
- MemWrite  in  1  current MEM-stage instruction is a store
- Funct3  in  3  access type: 000 b, 001 h, 010 w, 100 bu, 101 hu
- Address  in  32  effective byte address (ALU_Result)
- WriteData  in  32  store source register value
- Stall  out  1  freezes PC and IF/ID/EX/MEM registers while high
- Fault  out  1  misaligned or illegal access, combinational
- ReadData  out  32  formatted load result, registered
- mem_req  out  1  memory request valid
- mem_we  out  1  request is a write
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte enables
- mem_wdata  out  32  store data
- mem_ready  in  1  memory accepts/completes the request this cycle
- mem_rdata  in  32  read word, valid when mem_ready is high

## Operation
- FSM states: IDLE, BUSY, DONE. Reset value is IDLE.
- A request is `req = MemRead | MemWrite`.
- Fault is evaluated in IDLE only. It is high when req is high and any of these hold:
  - MemRead and MemWrite are both high;
  - Funct3 is 011, 110 or 111;
  - store Funct3 is 100 or 101;
  - w with Address[1:0] != 0;
  - h/hu with Address[0] != 0.
- A faulting request issues no memory access and raises no Stall.
- IDLE → BUSY when req is high and Fault is low. On that edge, latch:
  - mem_addr = {Address[31:2], 2'b00};
  - mem_we = MemWrite;
  - Funct3;
  - Address[1:0];
  - mem_be, set by access type:
    - b: 4'b0001 << Address[1:0];
    - h: 4'b0011 << Address[1:0];
    - w: 4'b1111;
    - loads: 4'b1111.
  - mem_wdata, set by access type:
    - b: {4{WriteData[7:0]}};
    - h: {2{WriteData[15:0]}};
    - w: WriteData.
- BUSY:
  - mem_req = 1.
  - mem_addr, mem_we, mem_be and mem_wdata are held stable until mem_ready.
  - On mem_ready, go to DONE. On a load, also update ReadData:
    - b/bu: byte mem_rdata[8*off +: 8], sign- or zero-extended;
    - h/hu: half mem_rdata[16*off[1] +: 16], sign- or zero-extended;
    - w: mem_rdata.
- DONE:
  - Stall = 0, and the pipeline advances on this edge.
  - req seen in DONE belongs to the completing instruction and is ignored.
  - Always go to IDLE next.
- Stall = (IDLE & req & ~Fault) | BUSY.
- ReadData holds its value until the next completed load. Stores and faults leave it unchanged.
- mem_ready is ignored outside BUSY.
- rst at any time forces IDLE immediately and drops mem_req. An in-flight access is abandoned.
- Reset values:
  - mem_req, mem_we, Stall, Fault = 0;
  - mem_addr, mem_be, mem_wdata, ReadData = 0.

## Timing
- Cycle 0: IDLE with req. Stall is high combinationally.
- Cycle 1: BUSY with mem_req high.
- Cycle 1+k: mem_ready is sampled high after k ≥ 0 wait cycles.
- Cycle 2+k: DONE. Stall is low and ReadData is valid.
- Minimum occupancy is 3 cycles, with Stall high for 2.
- A back-to-back access enters IDLE on the cycle after DONE and is accepted that cycle.
- mem_req, mem_addr, mem_be, mem_we and mem_wdata are registered: no combinational path from any input.
- Stall and Fault are combinational from MemRead, MemWrite, Funct3, Address and state.

## Test plan
- Store word: sw, Address = 0x100, WriteData = 0xDEADBEEF, mem_ready on the first BUSY cycle.
  - Required: mem_addr = 0x100, mem_be = 1111, mem_we = 1, mem_wdata = 0xDEADBEEF.
  - Stall is high for cycles 0-1 and low in cycle 2.
- Load byte with sign extension: lb, Address = 0x103, mem_rdata = 0x80FF_1234, mem_ready after 3 wait cycles.
  - Required: mem_addr = 0x100, ReadData = 0xFFFFFF80.
  - Stall is high for 5 cycles.
- Byte-lane stores and unsigned half load:
  - sb at 0x202 with WriteData = 0x000000AB → mem_be = 0100, mem_wdata = 0xABABABAB;
  - sh at 0x202 → mem_be = 1100;
  - lhu at 0x202 with mem_rdata = 0x8001_0000 → ReadData = 0x00008001.
- Faults: lw at 0x101, sh at 0x003, Funct3 = 011, and MemRead with MemWrite both high.
  - Required: Fault = 1, Stall = 0, mem_req never asserted, ReadData unchanged.
- Reset in BUSY: assert rst while mem_ready = 0.
  - Required: mem_req = 0 and Stall = 0 immediately; all outputs at reset values.
  - After release, a new lw completes normally.
- Back-to-back accesses: lw then sw, with req held high through DONE.
  - Required: exactly two memory requests, none duplicated.
  - The second request is accepted in the IDLE cycle that follows DONE.
